hazard_scoreboard_unit: RTL and testbench

Parametrised successor to the 6-stage pipeline hazard unit. It resolves data hazards by forwarding from NUM_FWD later stages and by load-use stalls, and tracks multi-cycle (mul/div) results in a register scoreboard. It also handles control flushes from the branch stage and counts stall cycles. It sits beside the datapath; all state is local.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard_unit.sv | 97 +++++++++
 tb/tb_hazard_scoreboard_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - hazard/scoreboard signal bundle between datapath (master) and hazard unit (slave)
interface hazard_scoreboard_if #(
    parameter int NUM_FWD = 3,
    parameter int REG_W   = 5,
    parameter int PERF_W  = 32,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
);
    logic [REG_W-1:0]         Rs1D, Rs2D, RdD;
    logic                     UsesRs1D, UsesRs2D, RegWriteD, McOpD;
    logic [REG_W-1:0]         Rs1E, Rs2E, RdE;
    logic                     LoadE, McIssueE;
    logic [NUM_FWD*REG_W-1:0] RdFwd;
    logic [NUM_FWD-1:0]       RegWriteFwd, LoadFwd;
    logic [1:0]               PCSrcB;
    logic                     McDoneW;
    logic [REG_W-1:0]         McRdW;
    logic                     StallF, StallD, FlushD, FlushE, FlushB;
    logic [SEL_W-1:0]         ForwardAE, ForwardBE;
    logic                     McBusy;
    logic [PERF_W-1:0]        StallCycles;

    modport master (
        output Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, McOpD,
        output Rs1E, Rs2E, RdE, LoadE, McIssueE,
        output RdFwd, RegWriteFwd, LoadFwd, PCSrcB, McDoneW, McRdW,
        input  StallF, StallD, FlushD, FlushE, FlushB,
        input  ForwardAE, ForwardBE, McBusy, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, UsesRs1D, UsesRs2D, RdD, RegWriteD, McOpD,
        input  Rs1E, Rs2E, RdE, LoadE, McIssueE,
        input  RdFwd, RegWriteFwd, LoadFwd, PCSrcB, McDoneW, McRdW,
        output StallF, StallD, FlushD, FlushE, FlushB,
        output ForwardAE, ForwardBE, McBusy, StallCycles
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - forwarding, load-use/scoreboard/structural stalls, redirect flushes, stall counter
module hazard_scoreboard_unit #(
    parameter int NUM_FWD = 3,
    parameter int REG_W   = 5,
    parameter int MC_MAX  = 2,
    parameter int PERF_W  = 32,
    parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_scoreboard_if.slave   hz
);
    localparam int NREG  = 2 ** REG_W;
    localparam int CNT_W = $clog2(MC_MAX + 1);

    logic [NREG-1:0]   pending, pend_eff, done_mask, set_mask;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    eff_count, cnt_next;
    logic [PERF_W-1:0] stall_cycles;
    logic [SEL_W-1:0]  fwd_a, fwd_b;
    logic              live1, live2, ld_fwd, ld_stall, sb_stall, mc_stall;
    logic              stall, c_stall, issue;

    assign live1   = hz.UsesRs1D && (hz.Rs1D != '0);
    assign live2   = hz.UsesRs2D && (hz.Rs2D != '0);
    assign c_stall = (hz.PCSrcB != 2'b00);
    assign issue   = hz.McIssueE && !c_stall;

    // Descending scan so the lowest (youngest) matching source wins.
    always_comb begin
        logic [REG_W-1:0] rd_i;
        fwd_a  = '0;
        fwd_b  = '0;
        ld_fwd = 1'b0;
        rd_i   = '0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            rd_i = hz.RdFwd[i*REG_W +: REG_W];
            if (hz.RegWriteFwd[i] && (rd_i == hz.Rs1E) && (hz.Rs1E != '0))
                fwd_a = SEL_W'(i + 1);
            if (hz.RegWriteFwd[i] && (rd_i == hz.Rs2E) && (hz.Rs2E != '0))
                fwd_b = SEL_W'(i + 1);
            if (hz.RegWriteFwd[i] && hz.LoadFwd[i] &&
                ((live1 && (rd_i == hz.Rs1D)) || (live2 && (rd_i == hz.Rs2D))))
                ld_fwd = 1'b1;
        end
    end

    assign ld_stall = ld_fwd ||
                      (hz.LoadE && ((live1 && (hz.Rs1D == hz.RdE)) ||
                                    (live2 && (hz.Rs2D == hz.RdE))));

    // A completing result releases its dependants in the same cycle.
    assign done_mask = hz.McDoneW ? ({{(NREG-1){1'b0}}, 1'b1} << hz.McRdW) : '0;
    assign set_mask  = (issue && (hz.RdE != '0)) ? ({{(NREG-1){1'b0}}, 1'b1} << hz.RdE) : '0;
    assign pend_eff  = pending & ~done_mask;

    assign sb_stall = (live1 && pend_eff[hz.Rs1D]) ||
                      (live2 && pend_eff[hz.Rs2D]) ||
                      (hz.RegWriteD && (hz.RdD != '0) && pend_eff[hz.RdD]);

    assign eff_count = {1'b0, count} - {{CNT_W{1'b0}}, hz.McDoneW} + {{CNT_W{1'b0}}, issue};
    assign mc_stall  = hz.McOpD && (eff_count == (CNT_W+1)'(MC_MAX));
    assign stall     = ld_stall || sb_stall || mc_stall;

    always_comb begin
        cnt_next = {1'b0, count} + {{CNT_W{1'b0}}, issue};
        if (hz.McDoneW && (count != '0))
            cnt_next = cnt_next - 1'b1;
        if (cnt_next > (CNT_W+1)'(MC_MAX))
            cnt_next = (CNT_W+1)'(MC_MAX);
    end

    assign hz.StallF      = !reset && stall && !c_stall;
    assign hz.StallD      = !reset && stall && !c_stall;
    assign hz.FlushD      = reset || c_stall;
    assign hz.FlushB      = reset || c_stall;
    assign hz.FlushE      = reset || stall || c_stall;
    assign hz.ForwardAE   = reset ? '0 : fwd_a;
    assign hz.ForwardBE   = reset ? '0 : fwd_b;
    assign hz.McBusy      = !reset && (count != '0);
    assign hz.StallCycles = stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending      <= '0;
            count        <= '0;
            stall_cycles <= '0;
        end else begin
            // Set wins over clear; r0 is never tracked.
            pending <= (pend_eff | set_mask) & {{(NREG-1){1'b1}}, 1'b0};
            count   <= cnt_next[CNT_W-1:0];
            if (hz.StallD && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            assert (!(hz.McDoneW && (count == '0)));
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - directed and randomized checks of hazard_scoreboard_unit against a reference model
module tb_hazard_scoreboard_unit;
    localparam int NUM_FWD = 3;
    localparam int REG_W   = 5;
    localparam int MC_MAX  = 2;
    localparam int PERF_W  = 32;
    localparam int SEL_W   = $clog2(NUM_FWD + 1);

    typedef struct packed {
        logic             sf, sd, fd, fe, fb;
        logic [SEL_W-1:0] fa, fbs;
        logic             busy;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    bit     pend[2**REG_W];
    int     cnt;
    longint sc;

    hazard_scoreboard_if #(.NUM_FWD(NUM_FWD), .REG_W(REG_W), .PERF_W(PERF_W), .SEL_W(SEL_W)) bus ();

    hazard_scoreboard_unit #(.NUM_FWD(NUM_FWD), .REG_W(REG_W), .MC_MAX(MC_MAX),
                             .PERF_W(PERF_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .reset(reset), .hz(bus.slave)
    );

    always #5 clk = ~clk;

    function automatic int rdf(int i);
        return int'(bus.RdFwd[i*REG_W +: REG_W]);
    endfunction

    function automatic bit pend_now(int r);
        return pend[r] && !(bus.McDoneW && int'(bus.McRdW) == r);
    endfunction

    function automatic exp_t model_comb();
        exp_t e;
        int   srcs[$];
        bit   ld, sb, mc, st, cs;
        int   eff;
        e = '0;
        if (reset) begin
            e.fd = 1; e.fe = 1; e.fb = 1;
            return e;
        end
        for (int i = 0; i < NUM_FWD; i++) begin
            if (e.fa == 0 && bus.Rs1E != 0 && bus.RegWriteFwd[i] && rdf(i) == int'(bus.Rs1E)) e.fa = SEL_W'(i + 1);
            if (e.fbs == 0 && bus.Rs2E != 0 && bus.RegWriteFwd[i] && rdf(i) == int'(bus.Rs2E)) e.fbs = SEL_W'(i + 1);
        end
        if (bus.UsesRs1D && bus.Rs1D != 0) srcs.push_back(int'(bus.Rs1D));
        if (bus.UsesRs2D && bus.Rs2D != 0) srcs.push_back(int'(bus.Rs2D));
        ld = 0; sb = 0;
        foreach (srcs[k]) begin
            if (bus.LoadE && int'(bus.RdE) == srcs[k]) ld = 1;
            for (int i = 0; i < NUM_FWD; i++)
                if (bus.RegWriteFwd[i] && bus.LoadFwd[i] && rdf(i) == srcs[k]) ld = 1;
            if (pend_now(srcs[k])) sb = 1;
        end
        if (bus.RegWriteD && bus.RdD != 0 && pend_now(int'(bus.RdD))) sb = 1;
        cs  = (bus.PCSrcB != 0);
        eff = cnt - int'(bus.McDoneW) + ((bus.McIssueE && !cs) ? 1 : 0);
        mc  = bus.McOpD && (eff == MC_MAX);
        st  = ld || sb || mc;
        e.sf = st && !cs;
        e.sd = st && !cs;
        e.fd = cs;
        e.fb = cs;
        e.fe = st || cs;
        e.busy = (cnt != 0);
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = model_comb();
        if (reset) begin
            foreach (pend[r]) pend[r] = 0;
            cnt = 0;
            sc  = 0;
        end else begin
            if (bus.McDoneW) pend[bus.McRdW] = 0;
            if (bus.McIssueE && bus.PCSrcB == 0) begin
                if (bus.RdE != 0) pend[bus.RdE] = 1;
                cnt = cnt + 1;
            end
            if (bus.McDoneW && cnt > 0) cnt = cnt - 1;
            if (cnt > MC_MAX) cnt = MC_MAX;
            if (e.sd && sc < (64'd1 << PERF_W) - 1) sc = sc + 1;
        end
    end

    task automatic idle();
        bus.Rs1D = 0; bus.Rs2D = 0; bus.UsesRs1D = 0; bus.UsesRs2D = 0;
        bus.RdD = 0; bus.RegWriteD = 0; bus.McOpD = 0;
        bus.Rs1E = 0; bus.Rs2E = 0; bus.RdE = 0; bus.LoadE = 0; bus.McIssueE = 0;
        bus.RdFwd = '0; bus.RegWriteFwd = '0; bus.LoadFwd = '0;
        bus.PCSrcB = 0; bus.McDoneW = 0; bus.McRdW = 0;
    endtask

    task automatic cycle_in();
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset();
        cycle_in();
        reset = 1;
        bus.Rs1E = 5; bus.RdFwd[0 +: REG_W] = 5; bus.RegWriteFwd = 3'b001;
        bus.LoadE = 1; bus.RdE = 3; bus.Rs1D = 3; bus.UsesRs1D = 1;
        #1;
        vectors++;
        if ({bus.StallF, bus.StallD} !== 2'b00) begin miscompares++; $display("FAIL reset_stall got %b want 00", {bus.StallF, bus.StallD}); end
        vectors++;
        if ({bus.FlushD, bus.FlushE, bus.FlushB} !== 3'b111) begin miscompares++; $display("FAIL reset_flush got %b want 111", {bus.FlushD, bus.FlushE, bus.FlushB}); end
        vectors++;
        if (bus.ForwardAE !== 0 || bus.McBusy !== 0) begin miscompares++; $display("FAIL reset_fwd_busy got %0d/%0b want 0/0", bus.ForwardAE, bus.McBusy); end
        cycle_in();
        reset = 0;
        #1;
        vectors++;
        if (bus.StallCycles !== 0 || bus.McBusy !== 0) begin miscompares++; $display("FAIL reset_state got sc=%0d busy=%0b want 0/0", bus.StallCycles, bus.McBusy); end
    endtask

    task automatic test_forward_priority();
        cycle_in();
        bus.Rs1E = 5; bus.RdFwd[0 +: REG_W] = 5; bus.RdFwd[2*REG_W +: REG_W] = 5; bus.RegWriteFwd = 3'b101;
        bus.Rs2E = 6; bus.RdFwd[REG_W +: REG_W] = 6;
        #1;
        vectors++;
        if (bus.ForwardAE !== 1) begin miscompares++; $display("FAIL fwd_youngest got %0d want 1", bus.ForwardAE); end
        vectors++;
        if (bus.ForwardBE !== 0) begin miscompares++; $display("FAIL fwd_b_nowrite got %0d want 0", bus.ForwardBE); end
        bus.RegWriteFwd = 3'b110;
        #1;
        vectors++;
        if (bus.ForwardAE !== 3) begin miscompares++; $display("FAIL fwd_oldest got %0d want 3", bus.ForwardAE); end
        vectors++;
        if (bus.ForwardBE !== 2) begin miscompares++; $display("FAIL fwd_b_mid got %0d want 2", bus.ForwardBE); end
        bus.Rs1E = 0; bus.RdFwd[0 +: REG_W] = 0; bus.RegWriteFwd = 3'b111;
        #1;
        vectors++;
        if (bus.ForwardAE !== 0) begin miscompares++; $display("FAIL fwd_r0 got %0d want 0", bus.ForwardAE); end
    endtask

    task automatic test_load_use();
        longint sc0;
        sc0 = sc;
        cycle_in();
        bus.LoadE = 1; bus.RdE = 7; bus.Rs2D = 7; bus.UsesRs2D = 1;
        #1;
        vectors++;
        if ({bus.StallF, bus.StallD, bus.FlushE, bus.FlushD} !== 4'b1110) begin miscompares++; $display("FAIL load_use got %b want 1110", {bus.StallF, bus.StallD, bus.FlushE, bus.FlushD}); end
        cycle_in();
        bus.LoadE = 1; bus.RdE = 7; bus.Rs2D = 7; bus.UsesRs2D = 0;
        #1;
        vectors++;
        if (bus.StallD !== 0 || bus.FlushE !== 0) begin miscompares++; $display("FAIL load_use_unused got %b%b want 00", bus.StallD, bus.FlushE); end
        vectors++;
        if (longint'(bus.StallCycles) != sc0 + 1) begin miscompares++; $display("FAIL load_use_count got %0d want %0d", bus.StallCycles, sc0 + 1); end
        cycle_in();
        bus.RdFwd[REG_W +: REG_W] = 4; bus.RegWriteFwd = 3'b010; bus.LoadFwd = 3'b010;
        bus.Rs1D = 4; bus.UsesRs1D = 1;
        #1;
        vectors++;
        if (bus.StallD !== 1) begin miscompares++; $display("FAIL load_fwd_stall got %b want 1", bus.StallD); end
    endtask

    task automatic test_scoreboard();
        cycle_in();
        bus.McIssueE = 1; bus.RdE = 9;
        for (int k = 0; k < 3; k++) begin
            cycle_in();
            bus.Rs1D = 9; bus.UsesRs1D = 1;
            #1;
            vectors++;
            if (bus.StallD !== 1 || bus.McBusy !== 1) begin miscompares++; $display("FAIL sb_wait%0d got stall=%b busy=%b want 1/1", k, bus.StallD, bus.McBusy); end
        end
        cycle_in();
        bus.Rs1D = 9; bus.UsesRs1D = 1; bus.McDoneW = 1; bus.McRdW = 9;
        #1;
        vectors++;
        if (bus.StallD !== 0) begin miscompares++; $display("FAIL sb_release got %b want 0", bus.StallD); end
        cycle_in();
        bus.Rs1D = 9; bus.UsesRs1D = 1;
        #1;
        vectors++;
        if (bus.StallD !== 0 || bus.McBusy !== 0) begin miscompares++; $display("FAIL sb_cleared got stall=%b busy=%b want 0/0", bus.StallD, bus.McBusy); end
    endtask

    task automatic test_structural_waw();
        cycle_in(); bus.McIssueE = 1; bus.RdE = 10;
        cycle_in(); bus.McIssueE = 1; bus.RdE = 11;
        cycle_in(); bus.McOpD = 1;
        #1;
        vectors++;
        if (bus.StallD !== 1) begin miscompares++; $display("FAIL mc_full got %b want 1", bus.StallD); end
        cycle_in(); bus.McOpD = 1; bus.McDoneW = 1; bus.McRdW = 10;
        #1;
        vectors++;
        if (bus.StallD !== 0) begin miscompares++; $display("FAIL mc_done_frees got %b want 0", bus.StallD); end
        cycle_in(); bus.RegWriteD = 1; bus.RdD = 11;
        #1;
        vectors++;
        if (bus.StallD !== 1) begin miscompares++; $display("FAIL waw got %b want 1", bus.StallD); end
        bus.RdD = 12;
        #1;
        vectors++;
        if (bus.StallD !== 0) begin miscompares++; $display("FAIL waw_other got %b want 0", bus.StallD); end
        cycle_in(); bus.McOpD = 1; bus.McIssueE = 1; bus.RdE = 13;
        #1;
        vectors++;
        if (bus.StallD !== 1) begin miscompares++; $display("FAIL mc_issue_fill got %b want 1", bus.StallD); end
        cycle_in(); bus.McDoneW = 1; bus.McRdW = 11;
        cycle_in(); bus.McDoneW = 1; bus.McRdW = 13;
        cycle_in();
        #1;
        vectors++;
        if (bus.McBusy !== 0) begin miscompares++; $display("FAIL mc_drained got %b want 0", bus.McBusy); end
    endtask

    task automatic test_redirect();
        cycle_in();
        bus.PCSrcB = 2'b01; bus.McIssueE = 1; bus.LoadE = 1; bus.RdE = 7; bus.Rs2D = 7; bus.UsesRs2D = 1;
        #1;
        vectors++;
        if ({bus.FlushD, bus.FlushE, bus.FlushB, bus.StallF, bus.StallD} !== 5'b11100) begin
            miscompares++; $display("FAIL redirect got %b want 11100", {bus.FlushD, bus.FlushE, bus.FlushB, bus.StallF, bus.StallD});
        end
        cycle_in();
        bus.Rs1D = 7; bus.UsesRs1D = 1;
        #1;
        vectors++;
        if (bus.StallD !== 0 || bus.McBusy !== 0) begin miscompares++; $display("FAIL redirect_noissue got stall=%b busy=%b want 0/0", bus.StallD, bus.McBusy); end
    endtask

    task automatic test_reset_mid_op();
        cycle_in(); bus.McIssueE = 1; bus.RdE = 3;
        cycle_in(); bus.McIssueE = 1; bus.RdE = 4;
        cycle_in(); bus.Rs1D = 3; bus.UsesRs1D = 1;
        #1;
        vectors++;
        if (bus.StallD !== 1) begin miscompares++; $display("FAIL midop_pending got %b want 1", bus.StallD); end
        reset = 1;
        #1;
        vectors++;
        if ({bus.FlushD, bus.FlushE, bus.FlushB, bus.StallF, bus.McBusy} !== 5'b11100) begin
            miscompares++; $display("FAIL midop_in_reset got %b want 11100", {bus.FlushD, bus.FlushE, bus.FlushB, bus.StallF, bus.McBusy});
        end
        cycle_in();
        reset = 0;
        bus.Rs1D = 3; bus.UsesRs1D = 1; bus.Rs2D = 4; bus.UsesRs2D = 1;
        #1;
        vectors++;
        if ({bus.StallD, bus.McBusy} !== 2'b00 || bus.StallCycles !== 0) begin
            miscompares++; $display("FAIL midop_after got stall=%b busy=%b sc=%0d want 0/0/0", bus.StallD, bus.McBusy, bus.StallCycles);
        end
    endtask

    task automatic test_random();
        exp_t e, g;
        int   pq[$];
        for (int n = 0; n < 600; n++) begin
            cycle_in();
            bus.Rs1D = REG_W'($urandom_range(0, 7)); bus.Rs2D = REG_W'($urandom_range(0, 7));
            bus.UsesRs1D = 1'($urandom); bus.UsesRs2D = 1'($urandom);
            bus.RdD = REG_W'($urandom_range(0, 7)); bus.RegWriteD = 1'($urandom); bus.McOpD = 1'($urandom);
            bus.Rs1E = REG_W'($urandom_range(0, 7)); bus.Rs2E = REG_W'($urandom_range(0, 7));
            bus.RdE = REG_W'($urandom_range(0, 7)); bus.LoadE = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NUM_FWD; i++) bus.RdFwd[i*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
            bus.RegWriteFwd = NUM_FWD'($urandom);
            bus.LoadFwd = NUM_FWD'($urandom) & NUM_FWD'($urandom);
            bus.PCSrcB = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pq.delete();
            foreach (pend[r]) if (pend[r]) pq.push_back(r);
            if (cnt > 0 && $urandom_range(0, 2) == 0) begin
                bus.McDoneW = 1;
                bus.McRdW = (pq.size() > 0) ? REG_W'(pq[$urandom_range(0, pq.size() - 1)]) : REG_W'($urandom_range(0, 7));
            end
            if (cnt - int'(bus.McDoneW) < MC_MAX && $urandom_range(0, 2) == 0) bus.McIssueE = 1;
            #1;
            e = model_comb();
            g = {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.FlushB, bus.ForwardAE, bus.ForwardBE, bus.McBusy};
            vectors++;
            if (g !== e) begin miscompares++; $display("FAIL rand_outputs cyc %0d got %h want %h", n, g, e); end
            vectors++;
            if (longint'(bus.StallCycles) != sc) begin miscompares++; $display("FAIL rand_stallcycles cyc %0d got %0d want %0d", n, bus.StallCycles, sc); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1;
        idle();
        repeat (2) @(posedge clk);
        test_reset();
        test_forward_priority();
        test_load_use();
        test_scoreboard();
        test_structural_waw();
        test_redirect();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
